dilithium_out_unpacker: RTL and testbench

- Output stage directly downstream of the Dilithium core adapter.
- Buffers the 64-bit result stream (signature, public/secret key, verify result) with its last flag in a small FIFO.
- Re-emits the stream as 32-bit words for the host-side 32-bit bus/DMA.
- Tracks frame length and signals frame completion to the host.

---
 rtl/dilithium_out_unpacker.sv | 103 ++++++++++
 tb/tb_dilithium_out_unpacker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dilithium_out_unpacker.sv
// dilithium_out_unpacker: buffers 64-bit core results (with frame-last flag) and re-emits them as 32-bit words.
// Build option DILITHIUM_OUT_HI_FIRST_EN emits the upper half of each entry first; default is low half first.
module dilithium_out_unpacker #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [63:0]                s_data,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [31:0]                m_data,
   output logic                       m_last,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [CNT_W-1:0]           word_cnt,
   output logic                       frame_done
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          hs;
   logic          push;
   logic          pop;
   logic          free;

   // s_ready comes straight off the level register, so a pop never frees room for a same-cycle push
   assign s_ready = (level != LW'(DEPTH));
   assign m_valid = (level != '0);
   assign push    = s_valid && s_ready && !clear;
   assign pop     = m_valid && m_ready;
   assign free    = pop && hs;
   assign head    = mem[rd_ptr];

`ifdef DILITHIUM_OUT_HI_FIRST_EN
   assign m_data = hs ? head.data[31:0] : head.data[63:32];
`else
   assign m_data = hs ? head.data[63:32] : head.data[31:0];
`endif

   // last is tied to the second half regardless of half order
   assign m_last = m_valid && hs && head.last;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_last, s_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         hs     <= 1'b0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         hs     <= 1'b0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (free) rd_ptr <= rd_ptr + 1'b1;
         if (pop)  hs     <= !hs;
         unique case ({push, free})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // count restarts one cycle after the last word; a word taken in that cycle is the new frame's first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt   <= '0;
         frame_done <= 1'b0;
      end else if (clear) begin
         word_cnt   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && m_last;
         if (frame_done)
            word_cnt <= pop ? CNT_W'(1) : '0;
         else if (pop && (word_cnt != '1))
            word_cnt <= word_cnt + 1'b1;
      end
   end

   a_level_bound : assert property (@(posedge clk) disable iff (!rst) level <= LW'(DEPTH));
   a_hs_needs_entry : assert property (@(posedge clk) disable iff (!rst) hs |-> (level != '0));

endmodule

// File: tb/tb_dilithium_out_unpacker.sv
// Scoreboard bench for dilithium_out_unpacker: expected 32-bit words queued at push, compared at the output.
module tb_dilithium_out_unpacker;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam int LW    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [63:0]       s_data = '0;
   logic              s_last = 1'b0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [31:0]       m_data;
   logic              m_last;
   logic [LW-1:0]     level;
   logic [CNT_W-1:0]  word_cnt;
   logic              frame_done;

   int                errs = 0;
   int                checks = 0;
   logic [32:0]       exp_q[$];
   logic [CNT_W-1:0]  cnt_m = '0;
   logic              fd_m = 1'b0;
   logic              mon_take;
   logic              mon_last;

   dilithium_out_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .level(level), .word_cnt(word_cnt), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // push the two expected 32-bit beats of one entry when the handshake edge arrives
   task automatic send(input logic [63:0] d, input logic l);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      do begin @(negedge clk); n++; end while (!s_ready && n < 200);
      if (!s_ready) chk("send_timeout", s_ready, 1);
      @(posedge clk);
`ifdef DILITHIUM_OUT_HI_FIRST_EN
      exp_q.push_back({1'b0, d[63:32]});
      exp_q.push_back({l, d[31:0]});
`else
      exp_q.push_back({1'b0, d[31:0]});
      exp_q.push_back({l, d[63:32]});
`endif
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_fd(input logic [CNT_W-1:0] exp_cnt);
      int n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 100);
      chk("fd_seen", frame_done, 1);
      chk("fd_word_cnt", word_cnt, exp_cnt);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 200) begin @(negedge clk); n++; end
      chk("drain_timeout", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // output monitor: data/last against queue head every valid cycle, plus frame_done and word_cnt model
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_m_valid", m_valid, 0);
         exp_q.delete();
         cnt_m = '0;
         fd_m  = 1'b0;
      end else begin
         mon_take = m_valid && m_ready;
         mon_last = 1'b0;
         if (m_valid) begin
            if (exp_q.size() == 0) chk("spurious_out", m_valid, 0);
            else begin
               chk("out_word", {m_last, m_data}, exp_q[0]);
               mon_last = exp_q[0][32];
               if (mon_take) void'(exp_q.pop_front());
            end
         end
         chk("frame_done", frame_done, fd_m);
         chk("word_cnt", word_cnt, cnt_m);
         if (clear) begin
            exp_q.delete();
            cnt_m = '0;
            fd_m  = 1'b0;
         end else begin
            if (fd_m) cnt_m = mon_take ? CNT_W'(1) : '0;
            else if (mon_take && cnt_m != '1) cnt_m = cnt_m + 1'b1;
            fd_m = mon_take && mon_last;
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      #1;
      chk("reset_level", level, 0);
      chk("reset_s_ready", s_ready, 1);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_word_cnt", word_cnt, 0);
      chk("reset_frame_done", frame_done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // single entry, lowest latency
      m_ready = 1'b1;
      send(64'h1111_2222_3333_4444, 1'b1);
      chk("latency_m_valid", m_valid, 1);
      wait_fd(2);
      @(negedge clk);
      chk("cnt_restart", word_cnt, 0);
      wait_drain();

      // fill to full under backpressure; last on entry 8 pushes the count past saturation
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         send({32'hA000_0000 + i, 32'h5000_0000 + i}, i == DEPTH-1);
      chk("full_level", level, DEPTH);
      chk("full_s_ready", s_ready, 0);
      s_valid = 1'b1;
      s_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      s_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("full_no_push", level, DEPTH);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      chk("half_pop_level", level, DEPTH);
      chk("half_pop_s_ready", s_ready, 0);
      @(posedge clk); #1;
      chk("free_level", level, DEPTH-1);
      chk("free_s_ready", s_ready, 1);
      wait_fd(4'hF);
      wait_drain();

      // random backpressure over a 5-entry frame
      m_ready = 1'b0;
      fork
         for (int i = 0; i < 5; i++) send({$urandom(), $urandom()}, i == 4);
         wait_fd(10);
         begin
            repeat (60) begin @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1)); end
            m_ready = 1'b1;
         end
      join
      wait_drain();

      // back-to-back frames: 2 + 3 entries
      m_ready = 1'b1;
      fork
         begin
            send(64'hA1A1_A1A1_A0A0_A0A0, 1'b0);
            send(64'hA3A3_A3A3_A2A2_A2A2, 1'b1);
            send(64'hB1B1_B1B1_B0B0_B0B0, 1'b0);
            send(64'hB3B3_B3B3_B2B2_B2B2, 1'b0);
            send(64'hB5B5_B5B5_B4B4_B4B4, 1'b1);
         end
         begin wait_fd(4); wait_fd(6); end
      join
      wait_drain();

      // clear with a simultaneous push
      m_ready = 1'b0;
      send(64'hC1C1_C1C1_C0C0_C0C0, 1'b0);
      send(64'hC3C3_C3C3_C2C2_C2C2, 1'b0);
      send(64'hC5C5_C5C5_C4C4_C4C4, 1'b1);
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      s_last  = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      s_valid = 1'b0;
      chk("clear_level", level, 0);
      chk("clear_m_valid", m_valid, 0);
      chk("clear_word_cnt", word_cnt, 0);
      chk("clear_s_ready", s_ready, 1);
      @(posedge clk);
      #1 chk("clear_no_store", level, 0);

      // async reset in the middle of an entry (second half pending)
      send(64'h7777_6666_5555_4444, 1'b1);
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_level", level, 0);
      chk("arst_s_ready", s_ready, 1);
      chk("arst_word_cnt", word_cnt, 0);
      chk("arst_m_last", m_last, 0);
      chk("arst_frame_done", frame_done, 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      m_ready = 1'b1;
      send(64'h9999_8888_CAFE_F00D, 1'b1);
      wait_fd(2);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
